// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, column/byte helpers, forward S-box
// table and the FSM encoding of the serial SubBytes stage.
package aes_pkg;

    localparam int STATE_W  = 128;
    localparam int COL_W    = 32;
    localparam int BYTE_W   = 8;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_SUB  = 2'd1,
        SB_DONE = 2'd2
    } sb_state_e;

    // FIPS-197 forward substitution table, entry i at index i.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Column c of the state; column 0 occupies the top 32 bits.
    function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] s, input logic [1:0] c);
        return s[(STATE_W - 1) - COL_W * int'(c) -: COL_W];
    endfunction

    // State with column c replaced by v.
    function automatic logic [STATE_W-1:0] set_col(input logic [STATE_W-1:0] s, input logic [1:0] c,
                                                   input logic [COL_W-1:0] v);
        logic [STATE_W-1:0] r;
        r = s;
        r[(STATE_W - 1) - COL_W * int'(c) -: COL_W] = v;
        return r;
    endfunction

    // Byte of row r within a column word; row 0 occupies the top 8 bits.
    function automatic logic [BYTE_W-1:0] get_byte(input logic [COL_W-1:0] w, input logic [1:0] r);
        return w[(COL_W - 1) - BYTE_W * int'(r) -: BYTE_W];
    endfunction

endpackage

// File: rtl/subbytes_serial_if.sv
// Input/output handshake bundle of the serial SubBytes stage.
interface subbytes_serial_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;
    logic               busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup, shared with the key schedule.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = SBOX[din];
endmodule

// File: rtl/subbytes_serial.sv
// Iterative SubBytes: one 32-bit column per cycle through four S-box lanes,
// valid/ready handshake in and out, result held in a register until consumed.
module subbytes_serial
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    subbytes_serial_if.slave   bus
);

    sb_state_e          state_r, state_nxt_s;
    logic [1:0]         col_r, col_nxt_s;
    logic [STATE_W-1:0] data_r, data_nxt_s;
    logic               out_valid_r, busy_r;
    logic               in_ready_s;
    logic [COL_W-1:0]   col_word_s, sub_col_s;
    logic [7:0]         sbox_in_s  [NUM_COLS];
    logic [7:0]         sbox_out_s [NUM_COLS];

    // Split the current column into the four S-box lane inputs.
    always_comb begin
        col_word_s = get_col(data_r, col_r);
        for (int i = 0; i < NUM_COLS; i++) begin
            sbox_in_s[i] = get_byte(col_word_s, 2'(i));
        end
    end

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (sbox_in_s[g]),
            .dout (sbox_out_s[g])
        );
    end

    assign sub_col_s = {sbox_out_s[0], sbox_out_s[1], sbox_out_s[2], sbox_out_s[3]};

    // Next-state, column counter and datapath update; in_ready decode.
    always_comb begin
        state_nxt_s = state_r;
        col_nxt_s   = col_r;
        data_nxt_s  = data_r;
        in_ready_s  = 1'b0;
        case (state_r)
            SB_IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    data_nxt_s  = bus.in_state;
                    col_nxt_s   = 2'd0;
                    state_nxt_s = SB_SUB;
                end else begin
                    state_nxt_s = SB_IDLE;
                end
            end
            SB_SUB: begin
                data_nxt_s = set_col(data_r, col_r, sub_col_s);
                col_nxt_s  = col_r + 2'd1;
                if (col_r == 2'd3) begin
                    state_nxt_s = SB_DONE;
                end else begin
                    state_nxt_s = SB_SUB;
                end
            end
            SB_DONE: begin
                // The output handshake edge doubles as the next accept edge.
                in_ready_s = bus.out_ready;
                if (bus.out_ready && bus.in_valid) begin
                    data_nxt_s  = bus.in_state;
                    col_nxt_s   = 2'd0;
                    state_nxt_s = SB_SUB;
                end else if (bus.out_ready) begin
                    state_nxt_s = SB_IDLE;
                end else begin
                    state_nxt_s = SB_DONE;
                end
            end
            default: begin
                state_nxt_s = SB_IDLE;
                col_nxt_s   = 2'd0;
            end
        endcase
    end

    // State, counter, data and status flags; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SB_IDLE;
            col_r       <= 2'd0;
            data_r      <= {STATE_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            col_r       <= col_nxt_s;
            data_r      <= data_nxt_s;
            out_valid_r <= (state_nxt_s == SB_DONE);
            busy_r      <= (state_nxt_s == SB_SUB);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.out_state = data_r;

endmodule

// File: tb/tb_subbytes_serial.sv
// Self-checking bench for subbytes_serial; reference S-box is derived from
// GF(2^8) inversion plus the affine map rather than from a lookup table.
module tb_subbytes_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_asserts = 0;
    int   n_fails = 0;

    subbytes_serial_if bus ();

    subbytes_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        s = 8'h63;
        for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
        return s;
    endfunction

    // Substitute the first ncols columns (4 bytes each, most significant first).
    function automatic logic [127:0] ref_sub(input logic [127:0] v, input int ncols);
        logic [127:0] r = v;
        for (int b = 0; b < 4 * ncols; b++) r[127 - 8 * b -: 8] = sbox_ref(v[127 - 8 * b -: 8]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept v, measure latency and busy cycles, check result, consume it.
    task automatic run_block(input string tag, input logic [127:0] v, input logic [127:0] exp);
        int lat = 0;
        int busy_cnt = 0;
        bus.in_valid = 1'b1;
        bus.in_state = v;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_state = $urandom();
        if (bus.busy) busy_cnt++;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.busy) busy_cnt++;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(4));
        check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(4));
        check({tag, "_data"}, bus.out_state, exp);
        step();
        check({tag, "_idle_after"}, 128'({bus.out_valid, bus.busy, bus.in_ready}), 128'(3'b001));
    endtask

    initial begin
        logic [127:0] v, v2, hold;
        int t;
        bus.in_valid = 1'b0;
        bus.in_state = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_out_state", bus.out_state, 128'h0);
        rst_n = 1'b1;
        step();

        // Known FIPS-197 vector, model agreement and edge bytes
        check("model_kv", ref_sub(128'h193de3bea0f4e22b9ac68d2ae9f84808, 4),
              128'hd42711aee0bf98f1b8b45de51e415230);
        run_block("kv", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
        run_block("zeros", 128'h0, {16{8'h63}});
        run_block("ones", {16{8'hff}}, {16{8'h16}});
        for (int k = 0; k < 5; k++) begin
            v = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_block("rand", v, ref_sub(v, 4));
        end

        // Column ordering: intermediate register after E1..E4
        v = 128'h0000000000000000_00000000ffffffff;
        bus.in_valid = 1'b1;
        bus.in_state = v;
        step();
        bus.in_valid = 1'b0;
        check("col_e0", bus.out_state, v);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("col_e%0d", k), bus.out_state, ref_sub(v, k));
        end
        step();

        // Backpressure in DONE
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_state = v;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        hold = bus.out_state;
        check("bp_first", hold, ref_sub(v, 4));
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 128'({bus.out_valid, bus.in_ready}), 128'(2'b10));
            check("bp_stable", bus.out_state, hold);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", 128'(bus.in_ready), 128'(1));
        step();
        check("bp_released", 128'({bus.out_valid, bus.busy, bus.in_ready}), 128'(3'b001));

        // Back-to-back with in_valid held
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        v2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.in_valid = 1'b1;
        bus.in_state = v;
        step();
        bus.in_state = v2;
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        check("b2b_first", bus.out_state, ref_sub(v, 4));
        check("b2b_ready", 128'(bus.in_ready), 128'(1));
        t = 0;
        step();
        t++;
        bus.in_valid = 1'b0;
        check("b2b_no_bubble", 128'({bus.busy, bus.out_valid}), 128'(2'b10));
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            step();
            t++;
        end
        check("b2b_spacing", 128'(t), 128'(5));
        check("b2b_second", bus.out_state, ref_sub(v2, 4));
        step();

        // Garbage on in_valid during SUB is ignored
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.in_valid = 1'b1;
        bus.in_state = v;
        step();
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        bus.in_valid = 1'b0;
        check("ign_data", bus.out_state, ref_sub(v, 4));
        step();
        check("ign_no_accept", 128'({bus.out_valid, bus.busy}), 128'(2'b00));
        step();
        check("ign_still_idle", 128'(bus.busy), 128'(0));

        // Reset at E2
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.in_valid = 1'b1;
        bus.in_state = v;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", 128'({bus.out_valid, bus.busy, bus.in_ready}), 128'(3'b001));
        check("mid_rst_state", bus.out_state, 128'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 128'(bus.in_ready), 128'(1));
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block("post_rst", v, ref_sub(v, 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
